// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier:
// FSM state encoding, legal operand-width range and counter-width helper.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Legal range of the operand width parameter.
  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  // Iteration counter must be able to hold the value WIDTH itself.
  function automatic int cw_of(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/mult_seq_nbits_po.sv
// Datapath of the sequential multiplier: operand magnitude conversion,
// multiplicand register, 2*WIDTH accumulator with a WIDTH+1 bit adder,
// final sign fix-up and the held product register.
module mult_seq_nbits_po
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               iterate,
  input  logic               fix,
  input  logic               signed_mode,
  input  logic               neg,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product
);

  logic [WIDTH-1:0]   mcand_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [2*WIDTH-1:0] product_reg;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     sum;

  // Absolute value of a signed operand; the most negative value maps to
  // 2^(WIDTH-1), which still fits as an unsigned WIDTH-bit magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic sm, input logic [WIDTH-1:0] x);
    return (sm && x[WIDTH-1]) ? (~x + 1'b1) : x;
  endfunction

  // Operand magnitudes and the conditional add of one iteration (carry kept).
  always_comb begin
    mag_a = magnitude(signed_mode, a);
    mag_b = magnitude(signed_mode, b);
    sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]};
    if (acc_reg[0]) begin
      sum = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, mcand_reg};
    end
  end

  // Load / shift-add / sign fix-up registers, each gated by an FSM enable.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mcand_reg   <= '0;
      acc_reg     <= '0;
      product_reg <= '0;
    end else begin
      if (load) begin
        mcand_reg <= mag_a;
        acc_reg   <= {{WIDTH{1'b0}}, mag_b};
      end else if (iterate) begin
        // {carry, acc} shifted right by one
        acc_reg <= {sum, acc_reg[WIDTH-1:1]};
      end
      if (fix) begin
        product_reg <= neg ? (~acc_reg + 1'b1) : acc_reg;
      end
    end
  end

  assign product = product_reg;

endmodule

// File: rtl/mult_seq_nbits.sv
// Sequential shift-add multiplier top: control FSM (IDLE/RUN/FIX/DONE),
// iteration counter and sign flag, driving the datapath through enables.
// Result is ready WIDTH+2 cycles after start is sampled, in both modes.
module mult_seq_nbits
  import mult_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CW    = cw_of(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [CW-1:0]      count,
  output logic [2*WIDTH-1:0] product
);

  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  state_t        state_reg, state_next;
  logic [CW-1:0] count_reg, count_next;
  logic          neg_reg, neg_next;
  logic          load, iterate, fix;

  // Next-state, counter and datapath-enable decode.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    neg_next   = neg_reg;
    load       = 1'b0;
    iterate    = 1'b0;
    fix        = 1'b0;
    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
          count_next = '0;
          neg_next   = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
        end else if (state_reg == DONE) begin
          state_next = IDLE;
        end
      end
      RUN: begin
        iterate    = 1'b1;
        count_next = count_reg + 1'b1;
        if (count_reg == LAST_ITER) begin
          state_next = FIX;
        end
      end
      FIX: begin
        fix        = 1'b1;
        state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State, counter and sign flag registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
      count_reg <= '0;
      neg_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      neg_reg   <= neg_next;
    end
  end

  assign busy  = (state_reg == RUN) || (state_reg == FIX);
  assign done  = (state_reg == DONE);
  assign count = count_reg;

  mult_seq_nbits_po #(
    .WIDTH(WIDTH)
  ) u_po (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .iterate    (iterate),
    .fix        (fix),
    .signed_mode(signed_mode),
    .neg        (neg_reg),
    .a          (a),
    .b          (b),
    .product    (product)
  );

endmodule

// File: tb/tb_mult_seq_nbits.sv
// Directed bench for mult_seq_nbits: WIDTH=8 and WIDTH=3 instances,
// table of operand/product vectors plus hand-written multi-cycle sequences.
module tb_mult_seq_nbits;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=8 instance signals
  logic        reset8, start8, sm8;
  logic [7:0]  a8, b8;
  logic        busy8, done8;
  logic [3:0]  count8;
  logic [15:0] prod8;

  // WIDTH=3 instance signals
  logic        reset3, start3, sm3;
  logic [2:0]  a3, b3;
  logic        busy3, done3;
  logic [1:0]  count3;
  logic [5:0]  prod3;

  int n_cmp = 0;
  int n_bad = 0;

  mult_seq_nbits #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset8), .start(start8), .signed_mode(sm8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .count(count8), .product(prod8)
  );

  mult_seq_nbits #(.WIDTH(3)) u_dut3 (
    .clk(clk), .reset(reset3), .start(start3), .signed_mode(sm3),
    .a(a3), .b(b3), .busy(busy3), .done(done3), .count(count3), .product(prod3)
  );

  typedef struct {
    logic        sm;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One WIDTH=8 operation; lat counts rising edges including the accepting one.
  task automatic op8(input logic sm, input logic [7:0] a, input logic [7:0] b, output int lat);
    @(negedge clk);
    start8 = 1'b1; sm8 = sm; a8 = a; b8 = b;
    @(posedge clk); #1;
    start8 = 1'b0;
    // operands change after acceptance must not matter
    sm8 = ~sm; a8 = ~a; b8 = a ^ b;
    lat = 1;
    while (!done8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic op3(input logic sm, input logic [2:0] a, input logic [2:0] b, output int lat);
    @(negedge clk);
    start3 = 1'b1; sm3 = sm; a3 = a; b3 = b;
    @(posedge clk); #1;
    start3 = 1'b0;
    sm3 = ~sm; a3 = ~a; b3 = ~b;
    lat = 1;
    while (!done3 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, gap, reach8, seen;
    logic [3:0] prev;

    reset8 = 1'b0; start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
    reset3 = 1'b0; start3 = 1'b0; sm3 = 1'b0; a3 = '0; b3 = '0;

    vecs[0] = '{1'b0, 8'd13,  8'd11,  16'd143};
    vecs[1] = '{1'b0, 8'hFF,  8'hFF,  16'hFE01};
    vecs[2] = '{1'b1, 8'hFD,  8'h05,  16'hFFF1};
    vecs[3] = '{1'b0, 8'hFD,  8'h05,  16'h04F1};
    vecs[4] = '{1'b1, 8'h80,  8'h80,  16'h4000};
    vecs[5] = '{1'b1, 8'h80,  8'h7F,  16'hC080};
    vecs[6] = '{1'b0, 8'h80,  8'h80,  16'h4000};
    vecs[7] = '{1'b1, 8'hFF,  8'hFF,  16'h0001};
    vecs[8] = '{1'b1, 8'hFF,  8'h01,  16'hFFFF};
    vecs[9] = '{1'b0, 8'h00,  8'hC8,  16'h0000};

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",  {31'd0, busy8},  32'd0);
    check("rst_done",  {31'd0, done8},  32'd0);
    check("rst_count", {28'd0, count8}, 32'd0);
    check("rst_prod",  {16'd0, prod8},  32'd0);
    @(negedge clk);
    reset8 = 1'b1; reset3 = 1'b1;

    // table-driven WIDTH=8 vectors
    for (int i = 0; i < 10; i++) begin
      op8(vecs[i].sm, vecs[i].a, vecs[i].b, lat);
      check($sformatf("v%0d_latency", i), lat, 32'd10);
      check($sformatf("v%0d_product", i), {16'd0, prod8}, {16'd0, vecs[i].exp});
      check($sformatf("v%0d_busy_at_done", i), {31'd0, busy8}, 32'd0);
      check($sformatf("v%0d_count_at_done", i), {28'd0, count8}, 32'd8);
      @(posedge clk); #1;
      check($sformatf("v%0d_done_pulse", i), {31'd0, done8}, 32'd0);
      @(posedge clk); #1;
      check($sformatf("v%0d_prod_held", i), {16'd0, prod8}, {16'd0, vecs[i].exp});
      $display("vec %0d: sm=%0b a=%h b=%h product=%h latency=%0d", i, vecs[i].sm, vecs[i].a, vecs[i].b, prod8, lat);
    end

    // start pulses at cycles 2 and 5 of a running operation are ignored
    @(negedge clk);
    start8 = 1'b1; sm8 = 1'b0; a8 = 8'd13; b8 = 8'd11;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 1; reach8 = 0; prev = count8;
    while (!done8 && lat < 40) begin
      @(negedge clk);
      if (lat == 2 || lat == 5) begin
        start8 = 1'b1; sm8 = 1'b1; a8 = 8'hAA; b8 = 8'h33;
      end else begin
        start8 = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
      if (count8 == 4'd8 && prev != 4'd8) reach8++;
      prev = count8;
    end
    start8 = 1'b0;
    check("ign_latency", lat, 32'd10);
    check("ign_product", {16'd0, prod8}, 32'd143);
    check("ign_reach8_once", reach8, 32'd1);
    @(posedge clk); #1;
    check("ign_idle_after", {31'd0, busy8}, 32'd0);
    $display("ignored-start op: product=%0d latency=%0d count8_reached=%0d", prod8, lat, reach8);

    // reset in the middle of RUN
    @(negedge clk);
    start8 = 1'b1; sm8 = 1'b0; a8 = 8'd200; b8 = 8'd3;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 0;
    while (count8 != 4'd4 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("rst_mid_reached_count4", {28'd0, count8}, 32'd4);
    reset8 = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_busy",  {31'd0, busy8},  32'd0);
    check("rst_mid_count", {28'd0, count8}, 32'd0);
    check("rst_mid_prod",  {16'd0, prod8},  32'd0);
    check("rst_mid_done",  {31'd0, done8},  32'd0);
    reset8 = 1'b1;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done8) seen++;
    end
    check("rst_mid_no_done", seen, 32'd0);
    op8(1'b0, 8'd200, 8'd3, lat);
    check("rst_fresh_latency", lat, 32'd10);
    check("rst_fresh_product", {16'd0, prod8}, 32'h258);
    $display("reset-mid-run: fresh op product=%h latency=%0d", prod8, lat);

    // WIDTH=3 instance
    op3(1'b0, 3'd7, 3'd7, lat);
    check("w3_u77_latency", lat, 32'd5);
    check("w3_u77_product", {26'd0, prod3}, 32'd49);
    $display("w3 7*7 unsigned: product=%0d latency=%0d", prod3, lat);
    op3(1'b1, 3'b100, 3'b100, lat);
    check("w3_s44_product", {26'd0, prod3}, 32'd16);
    $display("w3 -4*-4 signed: product=%0d latency=%0d", prod3, lat);
    op3(1'b1, 3'b111, 3'b011, lat);
    check("w3_sm13_product", {26'd0, prod3}, 32'd61);
    $display("w3 -1*3 signed: product=%h latency=%0d", prod3, lat);

    // back-to-back with start held high
    @(negedge clk);
    start3 = 1'b1; sm3 = 1'b0; a3 = 3'd7; b3 = 3'd7;
    @(posedge clk); #1;
    a3 = 3'd5; b3 = 3'd6;
    lat = 1;
    while (!done3 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("b2b_first_latency", lat, 32'd5);
    check("b2b_first_product", {26'd0, prod3}, 32'd49);
    gap = 0;
    do begin
      @(posedge clk); #1;
      gap++;
    end while (!done3 && gap < 40);
    check("b2b_gap", gap, 32'd5);
    check("b2b_second_product", {26'd0, prod3}, 32'd30);
    $display("w3 back-to-back: second product=%0d gap=%0d", prod3, gap);
    @(negedge clk);
    start3 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
